// File: rtl/fc_vector_collector.sv
// Serial-to-parallel activation collector for a fully connected layer.
// Optional ping-pong buffering is enabled with FC_COLLECT_DBUF_EN.
module fc_vector_collector #(
  parameter int WIDTH = 8,
  parameter int IN    = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         x [0:IN-1],
  output logic                     vec_valid,
  input  logic                     vec_ready,
  output logic [$clog2(IN+1)-1:0]  fill_cnt,
  output logic                     short_frame
);

  localparam int CW = $clog2(IN+1);
  localparam int IW = $clog2(IN);
  localparam logic [CW-1:0] LAST = CW'(IN-1);

  logic          accept;
  logic          close;
  logic [IW-1:0] wr_idx;

  assign wr_idx = fill_cnt[IW-1:0];
  assign accept = in_valid && in_ready;
  assign close  = accept && (in_last || fill_cnt == LAST);

`ifdef FC_COLLECT_DBUF_EN

  logic [WIDTH-1:0] mem [0:1][0:IN-1];
  logic             wr_sel;
  logic             rd_sel;
  logic [1:0]       full;

  // A write and a release never target the same buffer: writing needs
  // !full[wr_sel], releasing needs full[rd_sel].
  assign in_ready  = !full[wr_sel];
  assign vec_valid = full[rd_sel];

  always_comb begin
    for (int unsigned i = 0; i < IN; i++) x[i] = mem[rd_sel][i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel      <= 1'b0;
      rd_sel      <= 1'b0;
      full        <= '0;
      fill_cnt    <= '0;
      short_frame <= 1'b0;
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned i = 0; i < IN; i++) mem[b][i] <= '0;
    end else begin
      short_frame <= close && (fill_cnt != LAST);
      if (vec_valid && vec_ready) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
        for (int unsigned i = 0; i < IN; i++) mem[rd_sel][i] <= '0;
      end
      if (accept) begin
        mem[wr_sel][wr_idx] <= in_data;
        if (close) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= ~wr_sel;
          fill_cnt     <= '0;
        end else begin
          fill_cnt <= fill_cnt + CW'(1);
        end
      end
    end
  end

`else

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] mem [0:IN-1];

  assign in_ready  = (state == FILL);
  assign vec_valid = (state == HOLD);

  always_comb begin
    for (int unsigned i = 0; i < IN; i++) x[i] = mem[i];
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FILL: if (close)     state_nx = HOLD;
      HOLD: if (vec_ready) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      fill_cnt    <= '0;
      short_frame <= 1'b0;
      for (int unsigned i = 0; i < IN; i++) mem[i] <= '0;
    end else begin
      state       <= state_nx;
      short_frame <= close && (fill_cnt != LAST);
      if (accept) begin
        mem[wr_idx] <= in_data;
        fill_cnt    <= fill_cnt + CW'(1);
      end
      if (vec_valid && vec_ready) begin
        fill_cnt <= '0;
        for (int unsigned i = 0; i < IN; i++) mem[i] <= '0;
      end
    end
  end

`endif

endmodule

// File: tb/tb_fc_vector_collector.sv
// Self-checking bench for fc_vector_collector: directed table plus
// multi-cycle sequences, with a scoreboard checking every emitted vector.
module tb_fc_vector_collector;

  localparam int WIDTH = 8;
  localparam int IN    = 128;
  localparam int CW    = $clog2(IN+1);

  typedef logic [IN*WIDTH-1:0] vec_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] x [0:IN-1];
  logic             vec_valid;
  logic             vec_ready;
  logic [CW-1:0]    fill_cnt;
  logic             short_frame;

  fc_vector_collector #(.WIDTH(WIDTH), .IN(IN)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .x(x), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .fill_cnt(fill_cnt), .short_frame(short_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t flat();
    vec_t v;
    for (int k = 0; k < IN; k++) v[k*WIDTH +: WIDTH] = x[k];
    return v;
  endfunction

  // Reference model and scoreboard, sampled mid-cycle.
  vec_t exp_q [$];
  vec_t mvec = '0;
  vec_t cur;
  vec_t prev_x;
  int   mcnt = 0;
  int   emitted = 0;
  logic hold_prev = 1'b0;
  logic rnd_ready = 1'b0;
  logic watch_ready = 1'b0;
  int   in_ready_low = 0;

  always @(negedge clk) begin
    cur = flat();
    if (rst) begin
      exp_q.delete();
      mvec = '0;
      mcnt = 0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && vec_valid) chk("x_stable", longint'(cur == prev_x), 1);
      if (vec_valid && vec_ready) begin
        emitted++;
        chk("vec_pending", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("vec_data", longint'(cur == exp_q.pop_front()), 1);
      end
      if (in_valid && in_ready) begin
        mvec[mcnt*WIDTH +: WIDTH] = in_data;
        mcnt++;
        if (mcnt == IN || in_last) begin
          exp_q.push_back(mvec);
          mvec = '0;
          mcnt = 0;
        end
      end
      if (watch_ready && !in_ready) in_ready_low++;
      hold_prev = vec_valid && !vec_ready;
      prev_x = cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) vec_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    int n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && n < 2000) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", longint'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic handshake();
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    vec_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    int nz = 0;
    for (int k = 0; k < IN; k++) if (x[k] != '0) nz++;
    chk({name, "_x_zero"}, nz, 0);
    chk({name, "_vec_valid"}, longint'(vec_valid), 0);
    chk({name, "_fill_cnt"}, longint'(fill_cnt), 0);
    chk({name, "_in_ready"}, longint'(in_ready), 1);
  endtask

  typedef struct {
    int               len;
    logic             last;
    logic [WIDTH-1:0] val;
    logic             exp_short;
    int               exp_cnt;
  } frame_t;

  frame_t tbl [5];

  initial begin
    int   bad;
    int   e0;
    int   n;
    int   len;
    vec_t snap;

    tbl[0] = '{len: 5,   last: 1'b1, val: 8'h7F, exp_short: 1'b1, exp_cnt: 5};
    tbl[1] = '{len: 1,   last: 1'b1, val: 8'hA5, exp_short: 1'b1, exp_cnt: 1};
    tbl[2] = '{len: 127, last: 1'b1, val: 8'h3C, exp_short: 1'b1, exp_cnt: 127};
    tbl[3] = '{len: 128, last: 1'b1, val: 8'hFF, exp_short: 1'b0, exp_cnt: 128};
    tbl[4] = '{len: 128, last: 1'b0, val: 8'h11, exp_short: 1'b0, exp_cnt: 128};

    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; vec_ready = 1'b0;
    do_reset();
    chk_idle("reset");
    chk("reset_short", longint'(short_frame), 0);

    // Full frame 0..127, held then released.
    bad = 0;
    for (int i = 0; i < IN; i++) begin
      send(8'(i), i == IN-1);
      if (i < IN-1 && vec_valid) bad++;
    end
    chk("full_early_valid", bad, 0);
    chk("full_vec_valid", longint'(vec_valid), 1);
    chk("full_short", longint'(short_frame), 0);
`ifdef FC_COLLECT_DBUF_EN
    chk("full_in_ready", longint'(in_ready), 1);
`else
    chk("full_in_ready", longint'(in_ready), 0);
`endif
    bad = 0;
    for (int k = 0; k < IN; k++) if (x[k] != 8'(k)) bad++;
    chk("full_x", bad, 0);
    snap = flat();
    repeat (10) tick();
    chk("full_hold_x", longint'(flat() == snap), 1);
    chk("full_hold_valid", longint'(vec_valid), 1);
    handshake();
    chk_idle("full_release");

    // Directed frame table.
    foreach (tbl[r]) begin
      for (int i = 0; i < tbl[r].len; i++) send(tbl[r].val, tbl[r].last && i == tbl[r].len-1);
      chk("tbl_vec_valid", longint'(vec_valid), 1);
      chk("tbl_short", longint'(short_frame), longint'(tbl[r].exp_short));
`ifdef FC_COLLECT_DBUF_EN
      chk("tbl_fill_cnt", longint'(fill_cnt), 0);
`else
      chk("tbl_fill_cnt", longint'(fill_cnt), tbl[r].exp_cnt);
`endif
      bad = 0;
      for (int k = 0; k < IN; k++)
        if (x[k] != ((k < tbl[r].len) ? tbl[r].val : 8'h00)) bad++;
      chk("tbl_x", bad, 0);
      tick();
      chk("tbl_short_end", longint'(short_frame), 0);
      chk("tbl_still_valid", longint'(vec_valid), 1);
      handshake();
      chk("tbl_released", longint'(vec_valid), 0);
      chk("tbl_in_ready", longint'(in_ready), 1);
    end

    // 300 beats without in_last, consumer always ready.
    e0 = emitted;
    vec_ready = 1'b1;
    for (int i = 0; i < 300; i++) send(8'(i), 1'b0);
    chk("stream_fill_cnt", longint'(fill_cnt), 44);
    chk("stream_vectors", emitted - e0, 2);
    vec_ready = 1'b0;
    do_reset();

    // Random gaps and consumer stalls over 20 frames.
    e0 = emitted;
    rnd_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, IN);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        send(8'($urandom), i == len-1);
      end
    end
    n = 0;
    while ((vec_valid || exp_q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_vectors", emitted - e0, 20);
    rnd_ready = 1'b0;
    vec_ready = 1'b0;

    // Reset mid-frame and mid-hold.
    e0 = emitted;
    for (int i = 0; i < 60; i++) send(8'(i+1), 1'b0);
    do_reset();
    chk_idle("rst_mid_frame");
    for (int i = 0; i < 10; i++) send(8'hA0, i == 9);
    chk("rst_pre_hold", longint'(vec_valid), 1);
    do_reset();
    chk_idle("rst_mid_hold");
    for (int i = 0; i < 3; i++) send(8'(i+1), i == 2);
    bad = 0;
    for (int k = 0; k < IN; k++) if (x[k] != ((k < 3) ? 8'(k+1) : 8'h00)) bad++;
    chk("rst_after_x", bad, 0);
    chk("rst_after_short", longint'(short_frame), 1);
    handshake();
    chk("rst_emitted", emitted - e0, 1);

`ifdef FC_COLLECT_DBUF_EN
    // Continuous full frames with an always-ready consumer.
    do_reset();
    e0 = emitted;
    in_ready_low = 0;
    watch_ready = 1'b1;
    vec_ready = 1'b1;
    for (int i = 0; i < 4*IN; i++) send(8'(i*3), (i % IN) == IN-1);
    tick();
    watch_ready = 1'b0;
    vec_ready = 1'b0;
    chk("dbuf_ready_low", in_ready_low, 0);
    chk("dbuf_vectors", emitted - e0, 4);

    // Both buffers fill while the consumer stalls.
    do_reset();
    for (int i = 0; i < 2*IN-1; i++) send(8'(i), 1'b0);
    chk("dbuf_ready_255", longint'(in_ready), 1);
    send(8'(2*IN-1), 1'b0);
    chk("dbuf_ready_256", longint'(in_ready), 0);
    chk("dbuf_fill_cnt", longint'(fill_cnt), 0);
    handshake();
    chk("dbuf_no_bubble", longint'(vec_valid), 1);
    chk("dbuf_ready_back", longint'(in_ready), 1);
    bad = 0;
    for (int k = 0; k < IN; k++) if (x[k] != 8'(k+IN)) bad++;
    chk("dbuf_second_x", bad, 0);
    handshake();
    chk("dbuf_empty", longint'(vec_valid), 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fc_vector_collector.md
Name: fc_vector_collector

Overview:
- Streaming front end for a fully connected layer neuron: accepts one activation per beat over a valid/ready handshake.
- Assembles IN activations into a parallel vector x[0:IN-1] and presents it, held stable, to the combinational layer until the consumer accepts it.
- Sits between the previous layer's serial output and the layer's parallel input bus.
- Short frames are zero-padded, so unused weight positions contribute nothing to the sum.

Parameters:
- WIDTH, 8, bits per activation; matches the layer's WIDTH.
- IN, 128, activations per vector; matches the layer's IN.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_data  input  WIDTH  activation beat
- in_valid  input  1  beat valid
- in_last  input  1  final beat of a frame; qualified by in_valid
- in_ready  output  1  collector can accept a beat
- x  output  unpacked array [WIDTH-1:0] x[0:IN-1]  assembled vector, drives layer x
- vec_valid  output  1  x holds a complete vector
- vec_ready  input  1  consumer accepts vector
- fill_cnt  output  $clog2(IN+1)  entries written into the current buffer
- short_frame  output  1  one-cycle pulse when a frame ends with fewer than IN beats

Behaviour:
- Reset (rst=1 at a clock edge), applied on the next edge:
  - all buffer entries = 0, fill_cnt = 0, state FILL
  - in_ready = 1 in FILL (see in_ready rule below), vec_valid = 0, short_frame = 0
- Reset mid-frame or mid-HOLD discards all partial and held data; no vector is emitted.
- in_ready is a registered-state decode, with no combinational path from vec_ready:
  - in_ready = 1 when state == FILL
  - in_ready = 0 when state == HOLD
- Beat accepted when in_valid && in_ready:
  - buf[fill_cnt] <= in_data; fill_cnt increments.
- Frame close: on an accepted beat with fill_cnt == IN-1 or in_last == 1:
  - next state HOLD; vec_valid = 1 in the following cycle (latency 1 from the last accepted beat).
  - If in_last closes with fill_cnt < IN-1, short_frame pulses in that following cycle.
  - Entries not written remain 0.
- in_last on beat index IN-1 is a normal frame; no short_frame pulse.
- Stream without in_last: the frame closes after IN beats, and the next beat starts a new frame. No beat is ever dropped or overwritten.
- HOLD:
  - x and vec_valid stay stable until vec_valid && vec_ready.
  - On that handshake: all entries cleared to 0, fill_cnt = 0, state FILL, vec_valid = 0.
  - in_ready = 1 in the next cycle.
- vec_ready while vec_valid = 0 is ignored.
- in_valid while in_ready = 0 is ignored (held by the producer).
- x is driven from registers only; no combinational path from in_data to x.
- Non-DBUF throughput: IN beats + 1 cycle to HOLD + at least 1 handshake cycle per vector.

Optional Feature:
- Macro: FC_COLLECT_DBUF_EN.
- When defined, the collector uses two ping-pong buffers A and B:
  - While one buffer is in HOLD driving x, the other fills, and in_ready stays 1.
  - in_ready = 0 only when both buffers are complete and the HOLD buffer is not yet accepted.
  - On the vec handshake, x switches to the other buffer in the same edge if it is complete; vec_valid stays 1 with no bubble. The released buffer is cleared.
  - Vectors are emitted strictly in fill order.
  - fill_cnt reports the filling buffer.
  - Sustained throughput is one beat per cycle.
- When undefined: single buffer; behaviour exactly as above.

Test Plan:
- Full frame, non-DBUF:
  - Stimulus: after reset, 128 back-to-back beats in_data = index (0..127), in_last on beat 127, vec_ready = 0.
  - Response: vec_valid rises 1 cycle after beat 127; x[k] == k for all k; in_ready = 0; short_frame never pulses.
  - Then hold vec_ready = 0 for 10 cycles → x stable. Pulse vec_ready → vec_valid = 0 and in_ready = 1 on the next cycle, fill_cnt = 0.
- Short frame:
  - Stimulus: 5 beats of 8'h7F with in_last on beat 5.
  - Response: vec_valid after 1 cycle; x[0..4] = 8'h7F, x[5..127] = 0; short_frame is a single-cycle pulse.
- No in_last:
  - Stimulus: 300 beats, vec_ready held 1.
  - Response: two vectors emitted, carrying beats 0–127 and 128–255; fill_cnt = 44 at the end; no lost or duplicated beats (scoreboard).
- Backpressure and gaps:
  - Stimulus: random in_valid gaps and random vec_ready stalls over 20 frames.
  - Response: every emitted vector matches the reference model; x never changes while vec_valid && !vec_ready.
- Reset mid-operation:
  - Stimulus: assert rst after 60 beats, then again during HOLD.
  - Response: the next cycle shows vec_valid = 0, fill_cnt = 0, in_ready = 1, all x = 0; the following frame is collected correctly.
- FC_COLLECT_DBUF_EN:
  - Stimulus: 4 full frames continuous, vec_ready = 1.
  - Response: in_ready never drops; vec_valid is back-to-back after the first vector; vectors are in order.
  - With vec_ready = 0: in_ready drops exactly after the 256th beat.
